// File: rtl/npu_pkg.sv
// Shared NPU definitions: memory/data widths, the read-sequencer state encoding
// and the convolution kernel footprint.
package npu_pkg;

  localparam int ADDR_W      = 14;
  localparam int DATA_W      = 16;
  localparam int KERNEL_TAPS = 9;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ISSUE,
    DRAIN
  } seq_state_e;

endpackage

// File: rtl/npu_sync_fifo.sv
// Synchronous FIFO with occupancy count; same-cycle push/pop keeps order and count.
module npu_sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/npu_conv_act_rd_seq.sv
// Activation/RGB read sequencer: walks the C x 3 x 3 window of one output pixel,
// issues reads (or pad bypasses) and streams realigned data through a credit-limited FIFO.
module npu_conv_act_rd_seq
  import npu_pkg::*;
#(
  parameter int ADDR_W     = npu_pkg::ADDR_W,
  parameter int DATA_W     = npu_pkg::DATA_W,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              cfg_src_rgb,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [7:0]        cfg_in_w,
  input  logic [7:0]        cfg_in_h,
  input  logic [6:0]        cfg_num_ch,
  input  logic [7:0]        cfg_out_row,
  input  logic [7:0]        cfg_out_col,
  output logic              busy,
  output logic              done,
  output logic              hw_act_mem_rd,
  output logic              hw_rgb_mem_rd,
  output logic              hw_act_mem_rd_bypass,
  output logic [ADDR_W-1:0] npu_act_mem_rd_addr,
  input  logic [DATA_W-1:0] npu_muxed_rgb_act_mem_rd_data,
  output logic [DATA_W-1:0] win_data,
  output logic              win_valid,
  input  logic              win_ready,
  output logic              win_last
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  seq_state_e state, state_nxt;
  logic issue, latch_cfg, setup_ld, done_nxt;

  logic              src_rgb_q;
  logic [ADDR_W-1:0] base_q;
  logic [7:0]        in_w_q, in_h_q, row_q, col_q;
  logic [6:0]        num_ch_q;

  logic [ADDR_W-1:0] plane, ch_row0, row_ptr;
  logic [6:0]        ch;
  logic [1:0]        ky, kx;
  logic [3:0]        tap;
  logic signed [9:0] x_pos, y_pos;
  logic              pad, last_elem;

  logic [RD_LAT:0]   vld_p, pad_p, last_p;
  logic [7:0]        in_flight, credit_used;
  logic              push, pop, fifo_empty;
  logic [DATA_W:0]   push_data, head;
  logic [CNT_W-1:0]  fifo_count;

  assign x_pos = $signed({2'b00, col_q}) + $signed({8'b0, kx}) - 10'sd1;
  assign y_pos = $signed({2'b00, row_q}) + $signed({8'b0, ky}) - 10'sd1;
  assign pad   = (x_pos < 10'sd0) || (x_pos >= $signed({2'b00, in_w_q})) ||
                 (y_pos < 10'sd0) || (y_pos >= $signed({2'b00, in_h_q}));
  assign last_elem = (ch == num_ch_q - 7'd1) && (tap == 4'(KERNEL_TAPS - 1));

  // Credits: elements still in the read pipe plus FIFO occupancy, minus the slot freed this cycle.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i <= RD_LAT; i++) in_flight = in_flight + 8'(vld_p[i]);
  end
  assign credit_used = in_flight + 8'(fifo_count) - 8'(pop);

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    latch_cfg = 1'b0;
    setup_ld  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: if (start) begin
        latch_cfg = 1'b1;
        if (cfg_num_ch == 7'd0) done_nxt = 1'b1;
        else                    state_nxt = SETUP;
      end
      SETUP: begin
        setup_ld  = 1'b1;
        state_nxt = ISSUE;
      end
      ISSUE: if (credit_used < 8'(FIFO_DEPTH)) begin
        issue = 1'b1;
        if (last_elem) state_nxt = DRAIN;
      end
      DRAIN: if (in_flight == 8'd0 &&
                 (fifo_count == '0 || (fifo_count == CNT_W'(1) && pop))) begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (latch_cfg) begin
      src_rgb_q <= cfg_src_rgb;
      base_q    <= cfg_base_addr;
      in_w_q    <= cfg_in_w;
      in_h_q    <= cfg_in_h;
      num_ch_q  <= cfg_num_ch;
      row_q     <= cfg_out_row;
      col_q     <= cfg_out_col;
    end
  end

  // Window walk: the only multiplies happen once in SETUP, then pointers advance by adds.
  always_ff @(posedge clk) begin
    if (setup_ld) begin
      plane   <= ADDR_W'(16'(in_w_q) * 16'(in_h_q));
      ch_row0 <= base_q + ADDR_W'(16'(row_q) * 16'(in_w_q)) - ADDR_W'(in_w_q);
      row_ptr <= base_q + ADDR_W'(16'(row_q) * 16'(in_w_q)) - ADDR_W'(in_w_q);
      ch      <= '0;
      ky      <= '0;
      kx      <= '0;
      tap     <= '0;
    end else if (issue) begin
      tap <= (tap == 4'(KERNEL_TAPS - 1)) ? 4'd0 : tap + 4'd1;
      if (kx == 2'd2) begin
        kx <= 2'd0;
        if (ky == 2'd2) begin
          ky      <= 2'd0;
          ch      <= ch + 7'd1;
          ch_row0 <= ch_row0 + plane;
          row_ptr <= ch_row0 + plane;
        end else begin
          ky      <= ky + 2'd1;
          row_ptr <= row_ptr + ADDR_W'(in_w_q);
        end
      end else begin
        kx <= kx + 2'd1;
      end
    end
  end

  // Stage p0: registered strobes and address.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hw_act_mem_rd        <= 1'b0;
      hw_rgb_mem_rd        <= 1'b0;
      hw_act_mem_rd_bypass <= 1'b0;
      npu_act_mem_rd_addr  <= '0;
    end else begin
      hw_act_mem_rd        <= issue && !pad && !src_rgb_q;
      hw_rgb_mem_rd        <= issue && !pad && src_rgb_q;
      hw_act_mem_rd_bypass <= issue && pad;
      if (issue) npu_act_mem_rd_addr <= pad ? '0 : row_ptr + ADDR_W'(x_pos[8:0]);
    end
  end

  // Stages p0..p(RD_LAT): element tags travel with the read until its data lands.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) vld_p <= '0;
    else         vld_p <= {vld_p[RD_LAT-1:0], issue};
  end

  always_ff @(posedge clk) begin
    pad_p  <= {pad_p[RD_LAT-1:0], pad};
    last_p <= {last_p[RD_LAT-1:0], last_elem};
  end

  assign push      = vld_p[RD_LAT];
  assign push_data = {last_p[RD_LAT], pad_p[RD_LAT] ? '0 : npu_muxed_rgb_act_mem_rd_data};
  assign pop       = win_valid && win_ready;

  npu_sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign win_valid = !fifo_empty;
  assign win_data  = win_valid ? head[DATA_W-1:0] : '0;
  assign win_last  = win_valid && head[DATA_W];

endmodule

// File: tb/tb_npu_conv_act_rd_seq.sv
// Scoreboard bench for npu_conv_act_rd_seq: stimulus queues expected strobes and
// window elements, a negedge monitor pops and compares as the DUT presents them.
module tb_npu_conv_act_rd_seq;
  import npu_pkg::*;

  localparam int AW = 14;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          cfg_src_rgb = 1'b0;
  logic [AW-1:0] cfg_base_addr = '0;
  logic [7:0]    cfg_in_w = 8'd4, cfg_in_h = 8'd4, cfg_out_row = '0, cfg_out_col = '0;
  logic [6:0]    cfg_num_ch = 7'd1;
  logic          busy, done, hw_act_mem_rd, hw_rgb_mem_rd, hw_act_mem_rd_bypass;
  logic [AW-1:0] npu_act_mem_rd_addr;
  logic [DW-1:0] rd_data, win_data;
  logic          win_valid, win_ready = 1'b1, win_last;

  always #5 clk = ~clk;

  npu_conv_act_rd_seq dut (
    .clk                           (clk),
    .resetn                        (resetn),
    .start                         (start),
    .cfg_src_rgb                   (cfg_src_rgb),
    .cfg_base_addr                 (cfg_base_addr),
    .cfg_in_w                      (cfg_in_w),
    .cfg_in_h                      (cfg_in_h),
    .cfg_num_ch                    (cfg_num_ch),
    .cfg_out_row                   (cfg_out_row),
    .cfg_out_col                   (cfg_out_col),
    .busy                          (busy),
    .done                          (done),
    .hw_act_mem_rd                 (hw_act_mem_rd),
    .hw_rgb_mem_rd                 (hw_rgb_mem_rd),
    .hw_act_mem_rd_bypass          (hw_act_mem_rd_bypass),
    .npu_act_mem_rd_addr           (npu_act_mem_rd_addr),
    .npu_muxed_rgb_act_mem_rd_data (rd_data),
    .win_data                      (win_data),
    .win_valid                     (win_valid),
    .win_ready                     (win_ready),
    .win_last                      (win_last)
  );

  // Memory model, two-cycle latency. Act words are 0x4000|addr; the RGB mux places
  // the byte 0xAB at bits [12:5]; a bypass returns junk the DUT must replace with 0.
  logic [DW-1:0] mem_p0, mem_p1;
  logic [7:0]    rgb_byte = 8'hAB;
  always @(posedge clk) begin
    if (hw_act_mem_rd)      mem_p0 <= 16'h4000 | 16'(npu_act_mem_rd_addr);
    else if (hw_rgb_mem_rd) mem_p0 <= {3'b000, rgb_byte, 5'b00000};
    else                    mem_p0 <= 16'hDEAD;
    mem_p1 <= mem_p0;
  end
  assign rd_data = mem_p1;

  typedef struct packed { logic [1:0] kind; logic [AW-1:0] addr; } stb_t;
  typedef struct packed { logic last; logic [DW-1:0] data; } out_t;
  stb_t exp_st[$];
  out_t exp_out[$];

  int tests = 0, fails = 0;
  int cyc = 0, start_cyc = 0, exp_done_cyc = -1, done_cnt = 0;
  int issued = 0, popped = 0, max_out = 0, first_stb = -1, last_stb = -1;
  int off9[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic ex(input int kind, input logic [AW-1:0] a, input logic last);
    stb_t s;
    out_t o;
    s.kind = 2'(kind);
    s.addr = (kind == 3) ? '0 : a;
    o.last = last;
    o.data = (kind == 1) ? (16'h4000 | 16'(a)) : (kind == 2) ? 16'h1560 : 16'h0000;
    exp_st.push_back(s);
    exp_out.push_back(o);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (resetn) begin
      int nstb;
      nstb = int'(hw_act_mem_rd) + int'(hw_rgb_mem_rd) + int'(hw_act_mem_rd_bypass);
      if (nstb > 1) chk("strobe_onehot", 32'(nstb), 1);
      if (nstb != 0) begin
        stb_t g, e;
        issued++;
        if (first_stb < 0) first_stb = cyc;
        last_stb = cyc;
        g.kind = hw_act_mem_rd ? 2'd1 : hw_rgb_mem_rd ? 2'd2 : 2'd3;
        g.addr = npu_act_mem_rd_addr;
        if (exp_st.size() == 0) chk("unexpected_strobe", 32'(g), 32'h0);
        else begin
          e = exp_st.pop_front();
          chk("strobe", 32'(g), 32'(e));
        end
      end
      if (issued - popped > max_out) max_out = issued - popped;
      if (win_valid && win_ready) begin
        out_t g, e;
        g.last = win_last;
        g.data = win_data;
        if (exp_out.size() == 0) chk("unexpected_elem", 32'(g), 32'h0);
        else begin
          e = exp_out.pop_front();
          chk("elem", 32'(g), 32'(e));
        end
        popped++;
        if (win_last) exp_done_cyc = cyc + 1;
      end
      if (done) begin
        done_cnt++;
        chk("done_cycle", 32'(cyc), 32'(exp_done_cyc));
        exp_done_cyc = -1;
      end
    end
  end

  task automatic kick(input logic rgb, input logic [AW-1:0] base, input logic [7:0] w, h,
                      input logic [6:0] c, input logic [7:0] r, col);
    @(posedge clk); #1;
    cfg_src_rgb = rgb; cfg_base_addr = base; cfg_in_w = w; cfg_in_h = h;
    cfg_num_ch = c; cfg_out_row = r; cfg_out_col = col;
    start = 1'b1; start_cyc = cyc; first_stb = -1; last_stb = -1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    bit seen;
    d0 = done_cnt;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk); #1;
      if (done_cnt != d0) seen = 1;
    end
    chk({name, "_done_seen"}, 32'(seen), 1);
    chk({name, "_strobes_left"}, 32'(exp_st.size()), 0);
    chk({name, "_elems_left"}, 32'(exp_out.size()), 0);
    chk({name, "_idle"}, 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("reset_outputs", {busy, done, hw_act_mem_rd, hw_rgb_mem_rd, hw_act_mem_rd_bypass,
                          win_valid, win_last}, 7'b0);
    chk("reset_addr_data", {npu_act_mem_rd_addr, win_data}, 30'h0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // Interior pixel, act source, full throughput.
    for (int i = 0; i < 9; i++) ex(1, 14'h100 + 14'(off9[i]), i == 8);
    kick(1'b0, 14'h100, 8'd4, 8'd4, 7'd1, 8'd1, 8'd1);
    chk("t1_busy", 32'(busy), 1);
    wait_done("t1", 60);
    chk("t1_strobe_span", 32'(last_stb - first_stb), 8);

    // Corner pixel: top row and left column are padding.
    ex(3, 0, 0); ex(3, 0, 0); ex(3, 0, 0); ex(3, 0, 0);
    ex(1, 14'h100, 0); ex(1, 14'h101, 0);
    ex(3, 0, 0); ex(1, 14'h104, 0); ex(1, 14'h105, 1);
    kick(1'b0, 14'h100, 8'd4, 8'd4, 7'd1, 8'd0, 8'd0);
    wait_done("t2", 60);

    // RGB source.
    for (int i = 0; i < 9; i++) ex(2, 14'h100 + 14'(off9[i]), i == 8);
    kick(1'b1, 14'h100, 8'd4, 8'd4, 7'd1, 8'd1, 8'd1);
    wait_done("t3", 60);

    // Two channels, plane offset 16.
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 9; i++) ex(1, 14'(16 * c + off9[i]), c == 1 && i == 8);
    kick(1'b0, 14'h000, 8'd4, 8'd4, 7'd2, 8'd1, 8'd1);
    wait_done("t4", 80);

    // Consumer stalls for 10 cycles mid-window.
    max_out = 0; issued = 0; popped = 0;
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 9; i++) ex(1, 14'(14'h40 + 16 * c + off9[i]), c == 1 && i == 8);
    kick(1'b0, 14'h040, 8'd4, 8'd4, 7'd2, 8'd1, 8'd1);
    for (int i = 0; i < 40 && popped < 4; i++) @(posedge clk);
    #1 win_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1 win_ready = 1'b1;
    wait_done("t5", 80);
    chk("t5_max_outstanding_ok", 32'(max_out <= 4), 1);
    chk("t5_all_popped", 32'(popped), 18);

    // Zero channels: done one cycle after start, no strobes.
    kick(1'b0, 14'h100, 8'd4, 8'd4, 7'd0, 8'd1, 8'd1);
    exp_done_cyc = start_cyc + 1;
    wait_done("t6", 10);

    // Start while busy is ignored.
    for (int i = 0; i < 9; i++) ex(1, 14'h200 + 14'(off9[i]), i == 8);
    kick(1'b0, 14'h200, 8'd4, 8'd4, 7'd1, 8'd1, 8'd1);
    begin
      int d0;
      d0 = done_cnt;
      @(posedge clk); #1;
      cfg_num_ch = 7'd0; cfg_base_addr = 14'h3000; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done("t7", 60);
      repeat (5) @(posedge clk);
      chk("t7_single_done", 32'(done_cnt - d0), 1);
    end

    // Reset in the middle of ISSUE.
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 9; i++) ex(1, 14'(16 * c + off9[i]), c == 1 && i == 8);
    kick(1'b0, 14'h000, 8'd4, 8'd4, 7'd2, 8'd1, 8'd1);
    repeat (4) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("t8_reset_outputs", {busy, done, hw_act_mem_rd, hw_rgb_mem_rd, hw_act_mem_rd_bypass,
                             win_valid, win_last}, 7'b0);
    chk("t8_reset_addr_data", {npu_act_mem_rd_addr, win_data}, 30'h0);
    exp_st.delete(); exp_out.delete(); exp_done_cyc = -1;
    issued = 0; popped = 0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (3) @(posedge clk);
    chk("t8_flushed_no_output", 32'({win_valid, busy}), 0);
    for (int i = 0; i < 9; i++) ex(1, 14'h100 + 14'(off9[i]), i == 8);
    kick(1'b0, 14'h100, 8'd4, 8'd4, 7'd1, 8'd1, 8'd1);
    wait_done("t8_rerun", 60);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
